// File: rtl/keypad_scan_controller.sv
// 4x3 matrix keypad scanner: row strobing, per-frame classification, press/release
// debounce FSM and a small key-event FIFO drained through a valid/ready handshake.
module keypad_scan_controller #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [2:0] key_col,
    output logic [3:0] key_row,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_held,
    output logic [3:0] held_code,
    output logic       ovf,
    input  logic       ovf_clr
);
    localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int AW1 = AW + 1;
    localparam logic [PW-1:0]  DIV_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  DEB_TARGET = CW'(DEBOUNCE_SCANS);
    localparam logic [AW1-1:0] FIFO_FULL  = AW1'(FIFO_DEPTH);
    localparam logic [3:0]     NO_KEY     = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_RELEASE} state_t;
    typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} frame_t;

    logic [PW-1:0]  r_presc;
    logic [3:0]     r_row;
    state_t         r_state;
    logic [3:0]     r_cand;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_accHits;
    logic           r_accMulti;
    logic [3:0]     r_accCode;
    logic [3:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [AW1-1:0] r_count;
    logic           r_ovf;

    logic           w_tick;
    logic           w_frameEnd;
    logic [1:0]     w_rowIdx;
    logic [1:0]     w_colIdx;
    logic [1:0]     w_nBits;
    logic [3:0]     w_sampleCode;
    logic [1:0]     w_accHitsNext;
    logic           w_accMultiNext;
    logic [3:0]     w_accCodeNext;
    frame_t         w_frame;
    state_t         w_stateNext;
    logic [3:0]     w_candNext;
    logic [CW-1:0]  w_cntNext;
    logic [CW-1:0]  w_cntInc;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_pushOk;
    logic           w_overflow;

    assign w_tick     = scan_en && (r_presc == DIV_LAST);
    assign w_frameEnd = w_tick && r_row[0];
    assign w_rowIdx   = r_row[3] ? 2'd0 : r_row[2] ? 2'd1 : r_row[1] ? 2'd2 : 2'd3;
    assign w_colIdx   = key_col[2] ? 2'd0 : key_col[1] ? 2'd1 : 2'd2;
    assign w_nBits    = {1'b0, key_col[0]} + {1'b0, key_col[1]} + {1'b0, key_col[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_row   <= 4'b1000;
        end else if (scan_en) begin
            r_presc <= (r_presc == DIV_LAST) ? '0 : r_presc + PW'(1);
            if (w_tick)
                r_row <= {r_row[0], r_row[3:1]};
        end
    end

    // Row 4 carries the non-numeric keys, so it does not follow the 3*row+col+1 pattern.
    always_comb begin
        w_sampleCode = NO_KEY;
        if (w_rowIdx == 2'd3) begin
            case (w_colIdx)
                2'd0:    w_sampleCode = 4'd12;
                2'd1:    w_sampleCode = 4'd0;
                default: w_sampleCode = 4'd11;
            endcase
        end else begin
            w_sampleCode = ({2'b00, w_rowIdx} * 4'd3) + {2'b00, w_colIdx} + 4'd1;
        end
    end

    always_comb begin
        w_accHitsNext  = r_accHits;
        w_accMultiNext = r_accMulti;
        w_accCodeNext  = r_accCode;
        if (w_nBits > 2'd1) begin
            w_accMultiNext = 1'b1;
        end else if (w_nBits == 2'd1) begin
            if (r_accHits != 2'd2)
                w_accHitsNext = r_accHits + 2'd1;
            w_accCodeNext = w_sampleCode;
        end
        if (w_accMultiNext || (w_accHitsNext >= 2'd2))
            w_frame = F_MULTI;
        else if (w_accHitsNext == 2'd1)
            w_frame = F_SINGLE;
        else
            w_frame = F_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accHits  <= 2'd0;
            r_accMulti <= 1'b0;
            r_accCode  <= NO_KEY;
        end else if (w_tick) begin
            r_accHits  <= r_row[0] ? 2'd0   : w_accHitsNext;
            r_accMulti <= r_row[0] ? 1'b0   : w_accMultiNext;
            r_accCode  <= r_row[0] ? NO_KEY : w_accCodeNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cand  <= NO_KEY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cand  <= w_candNext;
            r_cnt   <= w_cntNext;
        end
    end

    // The candidate register doubles as the held code while PRESSED/RELEASE.
    always_comb begin
        w_stateNext = r_state;
        w_candNext  = r_cand;
        w_cntNext   = r_cnt;
        w_push      = 1'b0;
        w_cntInc    = r_cnt + CW'(1);
        if (w_frameEnd) begin
            case (r_state)
                S_IDLE: begin
                    if (w_frame == F_SINGLE) begin
                        w_stateNext = S_CAND;
                        w_candNext  = w_accCodeNext;
                        w_cntNext   = CW'(1);
                    end
                end
                S_CAND: begin
                    if ((w_frame == F_SINGLE) && (w_accCodeNext == r_cand)) begin
                        w_cntNext = w_cntInc;
                        if (w_cntInc == DEB_TARGET) begin
                            w_stateNext = S_PRESSED;
                            w_push      = 1'b1;
                        end
                    end else if (w_frame == F_SINGLE) begin
                        w_candNext = w_accCodeNext;
                        w_cntNext  = CW'(1);
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (w_frame == F_NONE) begin
                        w_stateNext = S_RELEASE;
                        w_cntNext   = CW'(1);
                    end
                end
                default: begin
                    if (w_frame == F_NONE) begin
                        w_cntNext = w_cntInc;
                        if (w_cntInc == DEB_TARGET)
                            w_stateNext = S_IDLE;
                    end else begin
                        w_stateNext = S_PRESSED;
                    end
                end
            endcase
        end
    end

    assign w_pop      = key_valid && key_ready;
    assign w_full     = (r_count == FIFO_FULL);
    assign w_pushOk   = w_push && (!w_full || w_pop);
    assign w_overflow = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_pushOk)
            r_mem[r_wrPtr] <= r_cand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pushOk)
                r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + AW'(1);
            if (w_pushOk && !w_pop)
                r_count <= r_count + AW1'(1);
            else if (!w_pushOk && w_pop)
                r_count <= r_count - AW1'(1);
            if (w_overflow)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign key_row   = r_row;
    assign key_valid = (r_count != '0);
    assign key_code  = key_valid ? r_mem[r_rdPtr] : NO_KEY;
    assign key_held  = (r_state == S_PRESSED) || (r_state == S_RELEASE);
    assign held_code = key_held ? r_cand : NO_KEY;
    assign ovf       = r_ovf;

endmodule
